// File: rtl/ibex_register_file_mport.sv
// Multi-port flip-flop register file with write arbitration, clear engine and error flag.
// Optional write-to-read forwarding when IBEX_RF_BYPASS_EN is defined.
module ibex_register_file_mport #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          NumRdPorts  = 2,
  parameter int unsigned          NumWrPorts  = 2,
  parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumRdPorts*5-1:0]          raddr_i,
  output logic [NumRdPorts*DataWidth-1:0]  rdata_o,
  input  logic [NumWrPorts*5-1:0]          waddr_i,
  input  logic [NumWrPorts*DataWidth-1:0]  wdata_i,
  input  logic [NumWrPorts-1:0]            we_i,
  input  logic                             clear_i,
  output logic                             busy_o,
  output logic                             err_o
);

  localparam int unsigned AW       = RV32E ? 4 : 5;
  localparam int unsigned NumWords = 2 ** AW;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e               state_q;
  logic [AW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 err_q;
  logic                 err_d;
  logic                 coll;
  logic [NumWrPorts-1:0] legal;
  logic [NumWrPorts-1:0] wr_ok;

  logic [DataWidth-1:0] rf_q [1:NumWords-1];
  logic [DataWidth-1:0] rf_d [1:NumWords-1];

  // legal: enabled, nonzero and in range; wr_ok additionally requires IDLE
  always_comb begin
    coll  = 1'b0;
    legal = '0;
    wr_ok = '0;
    for (int k = 0; k < NumWrPorts; k++) begin
      legal[k] = we_i[k] && (waddr_i[5*k+:5] != 5'd0) &&
                 !(RV32E && waddr_i[5*k+4]);
      wr_ok[k] = legal[k] && (state_q == IDLE);
    end
    for (int k = 1; k < NumWrPorts; k++) begin
      for (int j = 0; j < k; j++) begin
        if (legal[k] && legal[j] &&
            (waddr_i[5*k+:5] == waddr_i[5*j+:5])) begin
          coll = 1'b1;
        end
      end
    end
    err_d = (state_q == IDLE) ? coll : |legal;
  end

  // Later ports overwrite earlier ones, so the highest index wins
  always_comb begin
    rf_d = rf_q;
    for (int k = 0; k < NumWrPorts; k++) begin
      for (int i = 1; i < NumWords; i++) begin
        if (wr_ok[k] && (waddr_i[5*k+:5] == 5'(i))) begin
          rf_d[i] = wdata_i[DataWidth*k+:DataWidth];
        end
      end
    end
    if (state_q == CLEAR) begin
      for (int i = 1; i < NumWords; i++) begin
        if (cnt_q == AW'(i)) begin
          rf_d[i] = WordZeroVal;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NumWords; i++) begin
        rf_q[i] <= WordZeroVal;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_d;
      unique case (state_q)
        IDLE: begin
          if (clear_i) begin
            state_q <= CLEAR;
            cnt_q   <= AW'(1);
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == AW'(NumWords - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign err_o  = err_q;

  for (genvar p = 0; p < NumRdPorts; p++) begin : g_rd
    logic [4:0]           ra;
    logic [DataWidth-1:0] rd;
    assign ra = raddr_i[5*p+:5];
    // Out-of-range RV32E addresses never match an entry and fall back to zero
    always_comb begin
      rd = WordZeroVal;
      for (int i = 1; i < NumWords; i++) begin
        if (ra == 5'(i)) begin
          rd = rf_q[i];
        end
      end
`ifdef IBEX_RF_BYPASS_EN
      for (int k = 0; k < NumWrPorts; k++) begin
        if (wr_ok[k] && (waddr_i[5*k+:5] == ra)) begin
          rd = wdata_i[DataWidth*k+:DataWidth];
        end
      end
`endif
    end
    assign rdata_o[DataWidth*p+:DataWidth] = rd;
  end

endmodule

// File: tb/tb_ibex_register_file_mport.sv
// Directed bench for ibex_register_file_mport, RV32I and RV32E instances.
module tb_ibex_register_file_mport;

  logic        clk;
  logic        rst_n;

  logic [9:0]  a_raddr, a_waddr;
  logic [63:0] a_rdata, a_wdata;
  logic [1:0]  a_we;
  logic        a_clr, a_busy, a_err;

  logic [9:0]  e_raddr, e_waddr;
  logic [63:0] e_rdata, e_wdata;
  logic [1:0]  e_we;
  logic        e_clr, e_busy, e_err;

  int total = 0;
  int bad   = 0;
  int n;
  logic [31:0] d;
  logic [31:0] acc;

  ibex_register_file_mport #(.RV32E(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .raddr_i(a_raddr), .rdata_o(a_rdata),
    .waddr_i(a_waddr), .wdata_i(a_wdata), .we_i(a_we),
    .clear_i(a_clr), .busy_o(a_busy), .err_o(a_err)
  );

  ibex_register_file_mport #(.RV32E(1'b1)) dut_e (
    .clk_i(clk), .rst_ni(rst_n),
    .raddr_i(e_raddr), .rdata_o(e_rdata),
    .waddr_i(e_waddr), .wdata_i(e_wdata), .we_i(e_we),
    .clear_i(e_clr), .busy_o(e_busy), .err_o(e_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic awr(input int p, input logic [4:0] a, input logic [31:0] v);
    a_waddr[5*p+:5]  = a;
    a_wdata[32*p+:32] = v;
    a_we[p]          = 1'b1;
  endtask

  task automatic ard(input int p, input logic [4:0] a, output logic [31:0] v);
    a_raddr[5*p+:5] = a;
    #1;
    v = a_rdata[32*p+:32];
  endtask

  task automatic ewr(input int p, input logic [4:0] a, input logic [31:0] v);
    e_waddr[5*p+:5]  = a;
    e_wdata[32*p+:32] = v;
    e_we[p]          = 1'b1;
  endtask

  task automatic erd(input int p, input logic [4:0] a, output logic [31:0] v);
    e_raddr[5*p+:5] = a;
    #1;
    v = e_rdata[32*p+:32];
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    a_raddr = '0; a_waddr = '0; a_wdata = '0; a_we = '0; a_clr = 1'b0;
    e_raddr = '0; e_waddr = '0; e_wdata = '0; e_we = '0; e_clr = 1'b0;

    #12;
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    rst_n = 1'b1;

    // every address reads zero after reset, on both ports
    for (int a = 0; a < 32; a++) begin
      ard(0, 5'(a), d);
      chk($sformatf("rst_rd0_x%0d", a), d, 32'd0);
      ard(1, 5'(31 - a), d);
      chk($sformatf("rst_rd1_x%0d", 31 - a), d, 32'd0);
    end
    chk("idle_busy", 32'(a_busy), 32'd0);
    chk("idle_err", 32'(a_err), 32'd0);

    tick;
    awr(0, 5'd5, 32'hDEAD_BEEF);
    tick;
    a_we = '0;
    ard(0, 5'd5, d);
    chk("wr_x5", d, 32'hDEAD_BEEF);
    awr(0, 5'd0, 32'hFFFF_FFFF);
    tick;
    a_we = '0;
    ard(1, 5'd0, d);
    chk("wr_x0", d, 32'd0);
    chk("wr_x0_err", 32'(a_err), 32'd0);

    // collision: port 1 wins
    awr(0, 5'd7, 32'h1111);
    awr(1, 5'd7, 32'h2222);
    tick;
    a_we = '0;
    chk("coll_err", 32'(a_err), 32'd1);
    ard(0, 5'd7, d);
    chk("coll_x7", d, 32'h2222);
    tick;
    chk("coll_err_clr", 32'(a_err), 32'd0);

    // two ports writing R0 is not a collision
    awr(0, 5'd0, 32'h1);
    awr(1, 5'd0, 32'h2);
    tick;
    a_we = '0;
    chk("r0_nocoll", 32'(a_err), 32'd0);

    for (int i = 1; i < 32; i++) begin
      awr(0, 5'(i), 32'h1000_0000 | 32'(i));
      tick;
    end
    a_we = '0;

    // clear with a same-cycle write to x2
    awr(0, 5'd2, 32'hCAFE);
    a_clr = 1'b1;
    tick;
    a_we = '0;
    a_clr = 1'b0;
    n = 32'(a_busy);
    chk("clr_busy", 32'(a_busy), 32'd1);
    ard(0, 5'd2, d);
    chk("clr_samecyc_wr", d, 32'hCAFE);
    tick; n += 32'(a_busy);
    tick; n += 32'(a_busy);
    tick; n += 32'(a_busy);
    ard(0, 5'd3, d);
    chk("clr_x3_zero", d, 32'd0);
    ard(0, 5'd31, d);
    chk("clr_x31_old", d, 32'h1000_001F);
    ard(0, 5'd4, d);
    chk("clr_x4_old", d, 32'h1000_0004);

    // write during clear is dropped and flagged; clear_i ignored
    awr(0, 5'd10, 32'h77);
    a_clr = 1'b1;
    ard(1, 5'd10, d);
    chk("clr_nofwd", d, 32'h1000_000A);
    tick; n += 32'(a_busy);
    a_we = '0;
    a_clr = 1'b0;
    chk("clr_wr_err", 32'(a_err), 32'd1);
    ard(1, 5'd10, d);
    chk("clr_wr_drop", d, 32'h1000_000A);
    tick; n += 32'(a_busy);
    chk("clr_err_clr", 32'(a_err), 32'd0);
    for (int g = 0; g < 40 && a_busy; g++) begin
      tick; n += 32'(a_busy);
    end
    chk("clr_busy_cycles", 32'(n), 32'd31);
    chk("clr_done_busy", 32'(a_busy), 32'd0);
    acc = '0;
    for (int i = 1; i < 32; i++) begin
      ard(1, 5'(i), d);
      acc = acc | d;
    end
    chk("clr_all_zero", acc, 32'd0);

    tick;
    awr(0, 5'd9, 32'hA5A5);
    ard(1, 5'd9, d);
`ifdef IBEX_RF_BYPASS_EN
    chk("bypass_same", d, 32'hA5A5);
`else
    chk("nobypass_same", d, 32'd0);
`endif
    tick;
    a_we = '0;
    ard(1, 5'd9, d);
    chk("bypass_next", d, 32'hA5A5);

`ifdef IBEX_RF_BYPASS_EN
    awr(0, 5'd12, 32'h1111);
    awr(1, 5'd12, 32'h3333);
    ard(0, 5'd12, d);
    chk("bypass_coll", d, 32'h3333);
    tick;
    a_we = '0;
`endif

    // reset in the middle of a clear
    awr(0, 5'd31, 32'h5);
    tick;
    a_we = '0;
    a_clr = 1'b1;
    tick;
    a_clr = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(a_busy), 32'd0);
    ard(0, 5'd31, d);
    chk("midrst_x31", d, 32'd0);
    rst_n = 1'b1;

    // RV32E instance
    tick;
    ewr(0, 5'd4, 32'h44);
    tick;
    e_we = '0;
    ewr(0, 5'd20, 32'h1);
    erd(0, 5'd20, d);
    chk("e_x20_nofwd", d, 32'd0);
    tick;
    e_we = '0;
    erd(0, 5'd20, d);
    chk("e_x20_drop", d, 32'd0);
    erd(1, 5'd4, d);
    chk("e_x4_keep", d, 32'h44);
    e_clr = 1'b1;
    tick;
    e_clr = 1'b0;
    n = 32'(e_busy);
    for (int g = 0; g < 30 && e_busy; g++) begin
      tick; n += 32'(e_busy);
    end
    chk("e_busy_cycles", 32'(n), 32'd15);
    erd(1, 5'd4, d);
    chk("e_x4_cleared", d, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
